// File: rtl/hard_timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : hard_timer_counter
// Brief    : Bus-programmable 32-bit free-running timebase with prescaler,
//            sticky overflow flag and overflow interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module hard_timer_counter #(
    parameter int PRESC_W   = 16,
    parameter int RST_PRESC = 0
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] data_io,
    input  logic        cs_en,
    input  logic        wt_en,
    input  logic        rd_en,
    input  logic [3:0]  addr_in,
    output logic [31:0] timer_out,
    output logic        tick,
    output logic        ovf_int
);

    localparam logic [3:0] c_ADDR_COUNT  = 4'h0;
    localparam logic [3:0] c_ADDR_PRESC  = 4'h1;
    localparam logic [3:0] c_ADDR_CTRL   = 4'h2;
    localparam logic [3:0] c_ADDR_STATUS = 4'h3;

    logic [31:0]        r_count;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pcnt;
    logic               r_en;
    logic               r_ovf_ie;
    logic               r_ovf;

    logic               w_wr;
    logic               w_wr_count;
    logic               w_wr_presc;
    logic               w_wr_ctrl;
    logic               w_wr_status;
    logic               w_rd;
    logic               w_wrap;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rdata;

    assign w_wdata     = data_io;
    assign w_wr        = cs_en & wt_en;
    assign w_wr_count  = w_wr & (addr_in == c_ADDR_COUNT);
    assign w_wr_presc  = w_wr & (addr_in == c_ADDR_PRESC);
    assign w_wr_ctrl   = w_wr & (addr_in == c_ADDR_CTRL);
    assign w_wr_status = w_wr & (addr_in == c_ADDR_STATUS);
    assign w_rd        = cs_en & rd_en & ~wt_en;

    assign tick      = r_en & (r_pcnt == r_presc);
    // A COUNT write on the wrap cycle replaces the increment, so no overflow.
    assign w_wrap    = tick & (r_count == 32'hFFFF_FFFF) & ~w_wr_count;
    assign timer_out = r_count;
    assign ovf_int   = r_ovf & r_ovf_ie;

    // Prescaler restarts on any COUNT/PRESCALE write so a lowered PRESCALE
    // can never leave pcnt stranded above the compare value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_wr_count || w_wr_presc || !r_en || tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= w_wdata;
        end else if (tick) begin
            r_count <= r_count + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc  <= PRESC_W'(RST_PRESC);
            r_en     <= 1'b0;
            r_ovf_ie <= 1'b0;
        end else begin
            if (w_wr_presc) begin
                r_presc <= w_wdata[PRESC_W-1:0];
            end
            if (w_wr_ctrl) begin
                r_en     <= w_wdata[0];
                r_ovf_ie <= w_wdata[1];
            end
        end
    end

    // Hardware set takes priority over a simultaneous write-one-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_wrap | (r_ovf & ~(w_wr_status & w_wdata[0]));
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (addr_in)
            c_ADDR_COUNT:  w_rdata = r_count;
            c_ADDR_PRESC:  w_rdata = 32'(r_presc);
            c_ADDR_CTRL:   w_rdata = {30'd0, r_ovf_ie, r_en};
            c_ADDR_STATUS: w_rdata = {31'd0, r_ovf};
            default:       w_rdata = 32'd0;
        endcase
    end

    assign data_io = w_rd ? w_rdata : 32'bz;

endmodule
`default_nettype wire

// File: tb/tb_hard_timer_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hard_timer_counter
// Brief    : Directed, table-driven self-checking bench for hard_timer_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hard_timer_counter;

    localparam logic [3:0] c_COUNT  = 4'h0;
    localparam logic [3:0] c_PRESC  = 4'h1;
    localparam logic [3:0] c_CTRL   = 4'h2;
    localparam logic [3:0] c_STATUS = 4'h3;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        cs_en;
    logic        wt_en;
    logic        rd_en;
    logic [3:0]  addr_in;
    logic [31:0] timer_out;
    logic        tick;
    logic        ovf_int;
    logic        r_drv;
    logic [31:0] r_wdata;
    tri1  [31:0] data_io;

    int n_vec;
    int n_fail;

    assign data_io = r_drv ? r_wdata : 32'bz;

    hard_timer_counter #(
        .PRESC_W   (16),
        .RST_PRESC (0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .data_io   (data_io),
        .cs_en     (cs_en),
        .wt_en     (wt_en),
        .rd_en     (rd_en),
        .addr_in   (addr_in),
        .timer_out (timer_out),
        .tick      (tick),
        .ovf_int   (ovf_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cs_en = 1'b1; wt_en = 1'b1; rd_en = 1'b0; addr_in = a;
        r_drv = 1'b1; r_wdata = d;
        @(posedge clk);
        #1;
        cs_en = 1'b0; wt_en = 1'b0; r_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        cs_en = 1'b1; rd_en = 1'b1; wt_en = 1'b0; addr_in = a;
        #1;
        d = data_io;
        cs_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[11];
        logic [31:0] rd;
        int          cnt;
        bit          found;

        n_vec = 0; n_fail = 0;
        rst = 1'b1; cs_en = 1'b0; wt_en = 1'b0; rd_en = 1'b0;
        addr_in = 4'h0; r_drv = 1'b0; r_wdata = 32'h0;

        vecs[0]  = '{1'b1, c_PRESC,  32'h0001_ABCD, 32'h0000_ABCD};
        vecs[1]  = '{1'b1, c_COUNT,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, c_CTRL,   32'hFFFF_FFFE, 32'h0000_0002};
        vecs[3]  = '{1'b1, c_CTRL,   32'h0000_0000, 32'h0000_0000};
        vecs[4]  = '{1'b1, c_STATUS, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5]  = '{1'b1, 4'h4,     32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6]  = '{1'b1, 4'h7,     32'h1234_5678, 32'h0000_0000};
        vecs[7]  = '{1'b0, 4'hF,     32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{1'b0, c_COUNT,  32'h0000_0000, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, c_PRESC,  32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{1'b1, c_COUNT,  32'h0000_0000, 32'h0000_0000};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset timer_out", timer_out, 32'h0);
        check("reset tick", {31'd0, tick}, 32'h0);
        check("reset ovf_int", {31'd0, ovf_int}, 32'h0);
        bus_read(c_PRESC, rd);
        check("reset PRESCALE", rd, 32'h0);

        // Register access table, counter disabled throughout
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d addr%0h", i, vecs[i].addr), rd, vecs[i].exp);
        end

        // Asynchronous reset while counting
        bus_write(c_COUNT, 32'h0000_1234);
        bus_write(c_CTRL, 32'h3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst timer_out", timer_out, 32'h0);
        check("async rst ovf_int", {31'd0, ovf_int}, 32'h0);
        cs_en = 1'b1; rd_en = 1'b1; addr_in = c_CTRL;
        #1;
        check("async rst CTRL", data_io, 32'h0);
        cs_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // PRESCALE=3: one tick per 4 cycles
        bus_write(c_PRESC, 32'd3);
        bus_write(c_COUNT, 32'd0);
        bus_write(c_CTRL, 32'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (tick) cnt++;
        end
        check("presc3 count after 40", timer_out, 32'd10);
        check("presc3 tick pulses", cnt, 32'd10);
        bus_write(c_CTRL, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("disabled count holds", timer_out, 32'd10);
        check("disabled tick low", {31'd0, tick}, 32'h0);

        // Wrap with interrupt enabled, then W1C clear
        bus_write(c_COUNT, 32'hFFFF_FFFE);
        bus_write(c_PRESC, 32'd0);
        bus_write(c_CTRL, 32'd3);
        repeat (2) @(posedge clk);
        #1;
        check("wrap timer_out", timer_out, 32'h0);
        check("wrap ovf_int", {31'd0, ovf_int}, 32'h1);
        bus_read(c_STATUS, rd);
        check("wrap STATUS", rd, 32'h1);
        bus_write(c_STATUS, 32'h1);
        check("w1c ovf_int", {31'd0, ovf_int}, 32'h0);
        bus_read(c_STATUS, rd);
        check("w1c STATUS", rd, 32'h0);
        bus_write(c_CTRL, 32'd0);

        // COUNT write on a tick cycle
        bus_write(c_PRESC, 32'd3);
        bus_write(c_COUNT, 32'd0);
        bus_write(c_CTRL, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (tick) found = 1'b1;
        end
        check("tick seen before load", {31'd0, found}, 32'h1);
        cs_en = 1'b1; wt_en = 1'b1; addr_in = c_COUNT; r_drv = 1'b1; r_wdata = 32'h100;
        @(posedge clk);
        #1;
        cs_en = 1'b0; wt_en = 1'b0; r_drv = 1'b0;
        check("load on tick wins", timer_out, 32'h100);
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (tick) begin
                found = 1'b1;
                break;
            end
        end
        check("cycles to next tick", found ? cnt : 0, 32'd3);
        @(posedge clk);
        #1;
        check("count after next tick", timer_out, 32'h101);
        bus_write(c_CTRL, 32'd0);

        // W1C landing on the wrap edge: set wins
        bus_write(c_COUNT, 32'hFFFF_FFFD);
        bus_write(c_PRESC, 32'd0);
        bus_write(c_CTRL, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (timer_out == 32'hFFFF_FFFF) found = 1'b1;
        end
        check("reached all-ones", {31'd0, found}, 32'h1);
        cs_en = 1'b1; wt_en = 1'b1; addr_in = c_STATUS; r_drv = 1'b1; r_wdata = 32'h1;
        @(posedge clk);
        #1;
        cs_en = 1'b0; wt_en = 1'b0; r_drv = 1'b0;
        check("wrap edge timer_out", timer_out, 32'h0);
        bus_write(c_CTRL, 32'd0);
        bus_read(c_STATUS, rd);
        check("set beats clear", rd, 32'h1);
        check("ovf_int masked", {31'd0, ovf_int}, 32'h0);

        // Bus released when not selected, or when write strobe is high
        @(negedge clk);
        cs_en = 1'b0; rd_en = 1'b1; addr_in = c_COUNT;
        #1;
        check("hiz cs_en low", data_io, 32'hFFFF_FFFF);
        cs_en = 1'b1; wt_en = 1'b1; rd_en = 1'b1; addr_in = 4'h5;
        #1;
        check("hiz wt_en high", data_io, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        cs_en = 1'b0; wt_en = 1'b0; rd_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
